// File: rtl/mem_responder.sv
// LC-3 memory responder: one CPU request becomes a timed SRAM cycle, or a switch/hex-display I/O access.
// Latency: READY rises WAIT_CYCLES+1 cycles after accept for SRAM and 1 cycle after accept for I/O.
// Backpressure: a request held high across READY is not serviced again until MIO_EN is seen low.
module mem_responder #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MIO_EN,
  input  logic        WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] WDATA,
  output logic [15:0] RDATA,
  output logic        READY,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  input  logic [15:0] SW,
  output logic [15:0] HEX_OUT
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    REARM  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        armed;
  logic [3:0]  wait_cnt;
  logic        req_we;
  logic        accept;
  logic        is_io;
  logic        last_access;

  always_comb begin
    accept      = (state == IDLE) && MIO_EN && armed;
    is_io       = (ADDR == IO_ADDR);
    last_access = (state == ACCESS) && (wait_cnt == 4'd1);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Strobes and READY decode straight from registered state, so reset clears them at once.
  always_comb begin
    state_nxt = state;
    READY     = 1'b0;
    sram_ce_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_we_n = 1'b1;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = is_io ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        sram_ce_n = 1'b0;
        sram_oe_n = req_we;
        sram_we_n = ~req_we;
        if (wait_cnt == 4'd1) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        READY     = 1'b1;
        state_nxt = REARM;
      end
      REARM: begin
        if (armed || !MIO_EN) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      armed       <= 1'b1;
      wait_cnt    <= 4'd0;
      req_we      <= 1'b0;
      RDATA       <= 16'h0000;
      HEX_OUT     <= 16'h0000;
      sram_addr   <= 16'h0000;
      sram_dq_out <= 16'h0000;
    end else begin
      if (accept) begin
        armed  <= 1'b0;
        req_we <= WE;
        if (is_io) begin
          if (WE) begin
            HEX_OUT <= WDATA;
          end else begin
            RDATA <= SW;
          end
        end else begin
          // sram_addr doubles as the latched request address for the whole access.
          sram_addr <= ADDR;
          wait_cnt  <= WAIT_LOAD;
          if (WE) begin
            sram_dq_out <= WDATA;
          end
        end
      end else if (!MIO_EN) begin
        armed <= 1'b1;
      end

      if (state == ACCESS) begin
        wait_cnt <= wait_cnt - 4'd1;
      end

      if (last_access && !req_we) begin
        RDATA <= sram_dq_in;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus random transactions against a transaction-level model.
module tb_mem_responder;

  localparam int          W       = 2;
  localparam logic [15:0] IO_ADDR = 16'hFFFF;

  logic        Clk;
  logic        Reset;
  logic        MIO_EN;
  logic        WE;
  logic [15:0] ADDR;
  logic [15:0] WDATA;
  logic [15:0] RDATA;
  logic        READY;
  logic [15:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [15:0] SW;
  logic [15:0] HEX_OUT;

  int tests_run = 0;
  int tests_failed = 0;

  // Transaction-level model of the architecturally visible registers.
  logic [15:0] m_rdata = 16'h0;
  logic [15:0] m_hex   = 16'h0;
  logic [15:0] m_saddr = 16'h0;
  logic [15:0] m_sdq   = 16'h0;

  mem_responder #(.WAIT_CYCLES(W), .IO_ADDR(IO_ADDR)) dut (
    .Clk(Clk), .Reset(Reset), .MIO_EN(MIO_EN), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
    .RDATA(RDATA), .READY(READY), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .SW(SW), .HEX_OUT(HEX_OUT)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    check_eq({tag, ".rdata"}, RDATA, m_rdata);
    check_eq({tag, ".hex"}, HEX_OUT, m_hex);
    check_eq({tag, ".saddr"}, sram_addr, m_saddr);
    check_eq({tag, ".sdq"}, sram_dq_out, m_sdq);
    check_eq({tag, ".strobes"}, {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
  endtask

  // Takes the bus idle for two sampled edges so the responder is back in IDLE.
  task automatic release_bus();
    @(negedge Clk);
    MIO_EN = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
  endtask

  task automatic run_txn(input string tag, input logic [15:0] addr, input logic we,
                         input logic [15:0] wdata, input logic [15:0] dq, input logic [15:0] sw,
                         input bit scramble, input logic [15:0] alt_addr, input bit drop_mid,
                         input int hold);
    bit io;
    bit got;
    bit bus_bad;
    int lat, ce_cnt, oe_cnt, we_cnt, extra;
    io = (addr == IO_ADDR);
    @(negedge Clk);
    MIO_EN = 1'b1; WE = we; ADDR = addr; WDATA = wdata; sram_dq_in = dq; SW = sw;
    got = 0; bus_bad = 0; lat = 0; ce_cnt = 0; oe_cnt = 0; we_cnt = 0; extra = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(posedge Clk);
      #1;
      if (!sram_ce_n) begin
        ce_cnt++;
        if (sram_addr !== addr) bus_bad = 1;
        if (we && sram_dq_out !== wdata) bus_bad = 1;
      end
      if (!sram_oe_n) oe_cnt++;
      if (!sram_we_n) we_cnt++;
      if (READY) begin
        got = 1;
        lat = k;
      end
      if (k == 1 && scramble) begin
        ADDR = alt_addr; WE = ~we; WDATA = ~wdata;
      end
      if (k == 1 && drop_mid) MIO_EN = 1'b0;
    end
    check_eq({tag, ".latency"}, lat, io ? 1 : W + 1);
    check_eq({tag, ".ce_cycles"}, ce_cnt, io ? 0 : W);
    check_eq({tag, ".oe_cycles"}, oe_cnt, (!io && !we) ? W : 0);
    check_eq({tag, ".we_cycles"}, we_cnt, (!io && we) ? W : 0);
    check_eq({tag, ".bus_stable"}, bus_bad, 1'b0);
    if (io) begin
      if (we) m_hex = wdata; else m_rdata = sw;
    end else begin
      m_saddr = addr;
      if (we) m_sdq = wdata; else m_rdata = dq;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge Clk);
      #1;
      if (READY) extra++;
    end
    check_eq({tag, ".extra_ready"}, extra, 0);
    check_regs(tag);
    release_bus();
  endtask

  task automatic reset_mid_access();
    int lat;
    @(negedge Clk);
    MIO_EN = 1'b1; WE = 1'b0; ADDR = 16'h3000; sram_dq_in = 16'hCAFE;
    @(posedge Clk);
    @(posedge Clk);
    #2;
    check_eq("rst.in_access", sram_ce_n, 1'b0);
    Reset = 1'b0;
    #1;
    m_rdata = 16'h0; m_hex = 16'h0; m_saddr = 16'h0; m_sdq = 16'h0;
    check_eq("rst.ready", READY, 1'b0);
    check_regs("rst");
    repeat (3) @(posedge Clk);
    #1;
    check_eq("rst.no_ready", READY, 1'b0);
    @(negedge Clk);
    Reset = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge Clk);
      #1;
      if (k == 1) check_eq("rst.first_edge_accept", sram_ce_n, 1'b0);
      if (READY) lat = k;
    end
    check_eq("rst.relaunch_latency", lat, W + 1);
    m_rdata = 16'hCAFE; m_saddr = 16'h3000;
    check_regs("rst.relaunch");
    release_bus();
  endtask

  initial begin
    logic [15:0] a;
    bit          w;
    Reset = 1'b0; MIO_EN = 1'b0; WE = 1'b0; ADDR = 16'h0; WDATA = 16'h0;
    sram_dq_in = 16'h0; SW = 16'h0;
    #12;
    check_eq("reset.ready", READY, 1'b0);
    check_regs("reset");
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);

    run_txn("sram_rd", 16'h3000, 1'b0, 16'h0, 16'hBEEF, 16'h0, 0, 16'h0, 0, 0);
    run_txn("sram_wr", 16'h3001, 1'b1, 16'h1234, 16'h5555, 16'h0, 0, 16'h0, 0, 0);
    run_txn("io_wr", IO_ADDR, 1'b1, 16'h00A5, 16'h0, 16'h7777, 0, 16'h0, 0, 0);
    run_txn("io_rd", IO_ADDR, 1'b0, 16'h0, 16'h0, 16'h0F0F, 0, 16'h0, 0, 0);
    run_txn("hold8", 16'h2000, 1'b0, 16'h0, 16'hA1A1, 16'h0, 0, 16'h0, 0, 8);
    run_txn("after_hold", 16'h2001, 1'b0, 16'h0, 16'hB2B2, 16'h0, 0, 16'h0, 0, 2);
    run_txn("addr_change", 16'h3000, 1'b0, 16'h0, 16'hD00D, 16'h0, 1, 16'h4000, 0, 0);
    run_txn("drop_mid", 16'h3002, 1'b1, 16'h5A5A, 16'h0, 16'h0, 0, 16'h0, 1, 0);
    reset_mid_access();

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3) == 0) begin
        a = IO_ADDR;
      end else begin
        a = 16'($urandom);
        if (a == IO_ADDR) a = 16'hFFFE;
      end
      w = 1'($urandom);
      run_txn("rand", a, w, 16'($urandom), 16'($urandom), 16'($urandom),
              1'($urandom), 16'($urandom), 1'($urandom_range(3) == 0),
              int'($urandom_range(4)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
